// File: rtl/dist_ram_fifo_ctl.sv
// dist_ram_fifo_ctl: FIFO controller for a dual-port byte-enable RAM with registered port-B reads.
// Ports: clock/reset_n (async active-low); in_valid/in_ready/in_data write handshake;
// out_valid/out_ready/out_data read handshake; count occupancy; ram_*_a write port;
// ram_addr_b/ram_dout_b read port (ram_wen_b/ram_din_b tied off).
module dist_ram_fifo_ctl #(
  parameter int NUM_COL = 16,
  parameter int COL_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_COL*COL_WIDTH-1:0]   in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NUM_COL*COL_WIDTH-1:0]   out_data,
  output logic [ADDR_WIDTH:0]            count,
  output logic [NUM_COL-1:0]             ram_wen_a,
  output logic [ADDR_WIDTH-1:0]          ram_addr_a,
  output logic [NUM_COL*COL_WIDTH-1:0]   ram_din_a,
  output logic [ADDR_WIDTH-1:0]          ram_addr_b,
  output logic [NUM_COL-1:0]             ram_wen_b,
  output logic [NUM_COL*COL_WIDTH-1:0]   ram_din_b,
  input  logic [NUM_COL*COL_WIDTH-1:0]   ram_dout_b
);
  localparam int W = NUM_COL * COL_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0] ram_cnt;
  logic [1:0] buf_cnt;
  logic inflight, push, pop, issue, to_head;
  logic [2:0] occ;
  logic [W-1:0] buf0, buf1;
  // push is gated by reset so the RAM is never written while reset is held
  assign in_ready = count < DEPTH;
  assign push = reset_n & in_valid & in_ready;
  assign out_valid = buf_cnt != 2'd0;
  assign out_data = buf0;
  assign pop = out_valid & out_ready;
  // slots that will be occupied after this edge if nothing new is issued
  assign occ = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
  // ram_cnt only counts entries after their write edge, so no same-edge read/write
  assign issue = ram_cnt != '0 && occ < 3'd2;
  // returning data lands in the head slot when the buffer is empty after this edge's pop
  assign to_head = buf_cnt == 2'd0 || (buf_cnt == 2'd1 && pop);
  assign ram_wen_a = {NUM_COL{push}};
  assign ram_addr_a = wptr;
  assign ram_din_a = in_data;
  assign ram_addr_b = rptr;
  assign ram_wen_b = '0;
  assign ram_din_b = '0;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
      ram_cnt <= '0;
      count <= '0;
      buf_cnt <= '0;
      inflight <= 1'b0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      if (push) wptr <= wptr + ADDR_WIDTH'(1);
      if (issue) rptr <= rptr + ADDR_WIDTH'(1);
      ram_cnt <= ram_cnt + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(issue);
      count <= count + (ADDR_WIDTH+1)'(push) - (ADDR_WIDTH+1)'(pop);
      inflight <= issue;
      buf_cnt <= buf_cnt + 2'(inflight) - 2'(pop);
      if (pop) buf0 <= buf1;
      if (inflight && to_head) buf0 <= ram_dout_b;
      if (inflight && !to_head) buf1 <= ram_dout_b;
    end
  end
endmodule

// File: tb/tb_dist_ram_fifo_ctl.sv
// tb_dist_ram_fifo_ctl: directed and random checks of dist_ram_fifo_ctl against a queue model.
module tb_dist_ram_fifo_ctl;
  localparam int NUM_COL = 16;
  localparam int COL_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int W = NUM_COL * COL_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic clock = 1'b0;
  logic reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_data, out_data, ram_din_a, ram_din_b, ram_dout_b;
  logic [ADDR_WIDTH:0] count;
  logic [NUM_COL-1:0] ram_wen_a, ram_wen_b;
  logic [ADDR_WIDTH-1:0] ram_addr_a, ram_addr_b;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] q [$];
  logic [W-1:0] hold_d;
  logic hold_v = 1'b0;
  int errs = 0;
  int checks = 0;
  int pops = 0;
  dist_ram_fifo_ctl #(.NUM_COL(NUM_COL), .COL_WIDTH(COL_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .count(count),
    .ram_wen_a(ram_wen_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_addr_b(ram_addr_b), .ram_wen_b(ram_wen_b), .ram_din_b(ram_din_b), .ram_dout_b(ram_dout_b)
  );
  always #5 clock = ~clock;
  always @(posedge clock) begin
    for (int c = 0; c < NUM_COL; c++)
      if (ram_wen_a[c]) mem[ram_addr_a][c*COL_WIDTH +: COL_WIDTH] <= ram_din_a[c*COL_WIDTH +: COL_WIDTH];
    ram_dout_b <= mem[ram_addr_b];
  end
  function automatic logic [W-1:0] mk(int v);
    logic [W-1:0] r;
    for (int c = 0; c < NUM_COL; c++) r[c*COL_WIDTH +: COL_WIDTH] = COL_WIDTH'(v * NUM_COL + c);
    return r;
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    for (int c = 0; c < NUM_COL; c++) r[c*COL_WIDTH +: COL_WIDTH] = COL_WIDTH'($urandom);
    return r;
  endfunction
  task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // one clock: model the handshake just before the edge, then check occupancy after it
  task automatic step();
    logic acc;
    #1;
    if (hold_v) chk("stall_hold", out_data, hold_d);
    chk("in_ready", in_ready, q.size() < DEPTH);
    acc = reset_n && in_valid && q.size() < DEPTH;
    if (reset_n && out_valid && out_ready) begin
      checks++;
      assert (q.size() != 0) else begin
        errs++;
        $error("FAIL pop_empty observed=pop expected=no_pop");
      end
      if (q.size() != 0) begin
        chk("pop_data", out_data, q[0]);
        void'(q.pop_front());
      end
      pops++;
    end
    if (acc) q.push_back(in_data);
    hold_v = reset_n && out_valid && !out_ready;
    hold_d = out_data;
    @(negedge clock);
    if (!reset_n) q.delete();
    chk("count", count, q.size());
  endtask
  initial begin
    int g, base;
    logic first_seen;
    reset_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b0;
    in_data = mk(5);
    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wen_a", ram_wen_a, 0);
    @(negedge clock);
    in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    in_valid = 1'b1;
    in_data = {(W/8){8'hA5}};
    out_ready = 1'b1;
    #1;
    chk("push_wen_a", ram_wen_a, {NUM_COL{1'b1}});
    chk("push_addr_a", ram_addr_a, 0);
    chk("push_din_a", ram_din_a, {(W/8){8'hA5}});
    step();
    in_valid = 1'b0;
    chk("single_cnt1", count, 1);
    chk("single_nv1", out_valid, 0);
    #1;
    chk("idle_wen_a", ram_wen_a, 0);
    step();
    chk("single_nv2", out_valid, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, {(W/8){8'hA5}});
    step();
    chk("single_cnt0", count, 0);
    chk("single_empty", out_valid, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = mk(i);
      step();
    end
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    in_data = mk(99);
    #1;
    chk("full_no_wen", ram_wen_a, 0);
    step();
    chk("full_33rd", count, DEPTH);
    in_data = mk(77);
    out_ready = 1'b1;
    #1;
    chk("fullpop_in_ready", in_ready, 0);
    chk("fullpop_head", out_data, mk(0));
    step();
    chk("fullpop_count", count, DEPTH - 1);
    in_valid = 1'b0;
    g = 0;
    while (q.size() != 0 && g < 80) begin
      step();
      g++;
    end
    chk("drain_full", q.size(), 0);
    base = pops;
    first_seen = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_data = mk(1000 + i);
      step();
      chk("stream_cnt_le3", count <= 3, 1);
      if (first_seen && pops - base < 100) chk("stream_bubble", out_valid, 1);
      first_seen = first_seen | out_valid;
    end
    in_valid = 1'b0;
    g = 0;
    while (pops - base < 100 && g < 20) begin
      step();
      if (pops - base < 100) chk("stream_bubble", out_valid, 1);
      g++;
    end
    chk("stream_pops", pops - base, 100);
    for (int i = 0; i < 2000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = i < 1000 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      in_data = rnd();
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    g = 0;
    while (q.size() != 0 && g < 80) begin
      step();
      g++;
    end
    chk("drain_rand", q.size(), 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = mk(200 + i);
      step();
    end
    in_data = mk(210);
    out_ready = 1'b1;
    step();
    chk("pre_rst_count", count, 10);
    reset_n = 1'b0;
    hold_v = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_wen_a", ram_wen_a, 0);
    step();
    step();
    in_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    in_valid = 1'b1;
    in_data = {(W/8){8'h77}};
    step();
    in_valid = 1'b0;
    g = 0;
    while (q.size() != 0 && g < 8) begin
      if (out_valid) chk("post_rst_data", out_data, {(W/8){8'h77}});
      step();
      g++;
    end
    chk("post_rst_out", q.size(), 0);
    chk("post_rst_empty", out_valid, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dist_ram_fifo_ctl.md
DIST_RAM_FIFO_CTL -- requirements
Module: dist_ram_fifo_ctl

Interface
REQ-001 The block SHALL have parameter NUM_COL, default 16, giving the byte-enable column count of the attached RAM.
REQ-002 The block SHALL have parameter COL_WIDTH, default 32, giving the bits per column.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 5, giving a depth of DEPTH = 2**ADDR_WIDTH entries.
REQ-004 The block SHALL have W = NUM_COL*COL_WIDTH as its data width.
REQ-005 clock  in  1  single clock for all logic; one clock, all state on rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  write-side entry offered.
REQ-008 in_ready  out  1  write side can accept.
REQ-009 in_data  in  W  write-side payload.
REQ-010 out_valid  out  1  read-side entry presented.
REQ-011 out_ready  in  1  read side consumes.
REQ-012 out_data  out  W  read-side payload.
REQ-013 count  out  ADDR_WIDTH+1  occupancy, meaning entries accepted and not yet popped.
REQ-014 ram_wen_a  out  NUM_COL  column write enables to RAM port A.
REQ-015 ram_addr_a  out  ADDR_WIDTH  RAM port A address.
REQ-016 ram_din_a  out  W  RAM port A write data.
REQ-017 ram_addr_b  out  ADDR_WIDTH  RAM port B address.
REQ-018 ram_wen_b  out  NUM_COL  RAM port B write enables, tied to 0.
REQ-019 ram_din_b  out  W  RAM port B write data, tied to 0.
REQ-020 ram_dout_b  in  W  RAM port B registered read data, valid one edge after ram_addr_b is sampled.

Function
REQ-021 Push: when in_valid and in_ready are both high at an edge, the block SHALL drive ram_wen_a to all ones, ram_addr_a to wptr and ram_din_a to in_data in that cycle; wptr SHALL increment modulo DEPTH at that edge.
REQ-022 ram_wen_a SHALL be all zeros in every cycle without a push.
REQ-023 in_ready SHALL equal (count < DEPTH), derived from registered count only; there is no same-cycle pop pass-through, so a full FIFO refuses a push even while popping.
REQ-024 Internal ram_cnt SHALL hold the number of entries written but not yet read-issued; it SHALL increment at a push edge and decrement at a read-issue edge.
REQ-025 Read issue: in the cycle where ram_cnt > 0 and (buf_cnt + inflight - pop) < 2, the block SHALL present ram_addr_b = rptr; rptr SHALL increment modulo DEPTH and inflight SHALL be set at that edge.
REQ-026 An entry written at edge N SHALL NOT be read-issued before the cycle following edge N, which avoids same-edge read/write collision.
REQ-027 inflight data on ram_dout_b SHALL be captured into a 2-entry output buffer at the next edge; out_data and out_valid SHALL come from the buffer head.
REQ-028 Latency: an entry accepted at edge N with an empty pipeline SHALL appear with out_valid=1 after edge N+2.
REQ-029 A pop occurs when out_valid and out_ready are both high at an edge; the buffer head SHALL advance at that edge.
REQ-030 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-031 Throughput: the block SHALL sustain one push and one pop per cycle in steady state with no bubbles.
REQ-032 count SHALL be +1 on push-only, -1 on pop-only, and unchanged on simultaneous push and pop; count SHALL never exceed DEPTH.
REQ-033 Order SHALL be strict FIFO across pointer wrap-around.

Reset
REQ-034 While reset_n=0, wptr, rptr, ram_cnt, buf_cnt, inflight and count SHALL be 0, out_valid SHALL be 0, ram_wen_a SHALL be 0, and in_ready SHALL be 1.
REQ-035 Reset asserted mid-operation SHALL discard all entries, including any inflight read; RAM contents are not cleared and SHALL be ignored thereafter.

Verification
REQ-036 The bench SHALL cover a single push: push 0xA5 pattern at edge 1, out_ready=1 -> out_valid high after edge 3 with out_data=pattern, then count returns to 0.
REQ-037 The bench SHALL cover fill to full: 32 pushes with out_ready=0 -> count=32, in_ready=0, and a 33rd push is ignored.
REQ-038 The bench SHALL cover full with simultaneous pop: in_valid=1 and out_ready=1 at count=32 -> no push is accepted that cycle, and count=31 next.
REQ-039 The bench SHALL cover streaming wrap: 100 sequential values pushed and popped continuously with out_ready=1 -> outputs in order, no bubbles after the first, and count stays at 3 or less.
REQ-040 The bench SHALL cover random backpressure: random in_valid/out_ready over 2000 cycles -> scoreboard match, out_data stable while stalled.
REQ-041 The bench SHALL cover mid-stream reset: reset_n low with count=10 and a read inflight -> out_valid=0 and count=0 immediately, and the first post-reset push is output correctly.
